// File: rtl/nrz_frame_deframer.sv
// Sync-word hunting NRZ deframer: assembles fixed-length payloads into MSB-first bytes.
// Optional per-byte even-parity bit enabled by defining DEFRAMER_PARITY_CHECK_EN.
module nrz_frame_deframer #(
  parameter logic [7:0]  SYNC_WORD     = 8'hD5,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_nrz,
  input  logic       i_bit_en,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_locked,
  output logic [7:0] o_frame_cnt,
  output logic       o_parity_err
);

`ifdef DEFRAMER_PARITY_CHECK_EN
  localparam int unsigned SR_W     = 8;
  localparam logic [3:0]  LAST_BIT = 4'd8;
`else
  // Only 7 history bits are ever read; the 8-bit window is w_sr_next.
  localparam int unsigned SR_W     = 7;
  localparam logic [3:0]  LAST_BIT = 4'd7;
`endif
  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic {HUNT, DATA} state_t;

  state_t          r_state;
  logic [SR_W-1:0] r_sr;
  logic [3:0]      r_hunt_cnt;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_byte_cnt;

  logic [7:0] w_sr_next;
  logic       w_sync_hit;
  logic       w_byte_done;
  logic       w_last_byte;
  logic [7:0] w_byte;
  logic       w_perr;

  assign w_sr_next   = {r_sr[6:0], i_nrz};
  assign w_sync_hit  = (w_sr_next == SYNC_WORD) && (r_hunt_cnt >= 4'd7);
  assign w_byte_done = (r_bit_cnt == LAST_BIT);
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);

`ifdef DEFRAMER_PARITY_CHECK_EN
  // Current bit is the parity bit; the data byte is already in the shift register.
  assign w_byte = r_sr;
  assign w_perr = ^{r_sr, i_nrz};
`else
  assign w_byte = w_sr_next;
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= HUNT;
      r_sr         <= '0;
      r_hunt_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_locked     <= 1'b0;
      o_frame_cnt  <= '0;
      o_parity_err <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_parity_err <= 1'b0;
      if (i_bit_en) begin
        r_sr <= w_sr_next[SR_W-1:0];
        case (r_state)
          HUNT: begin
            if (r_hunt_cnt != 4'd8) r_hunt_cnt <= r_hunt_cnt + 4'd1;
            if (w_sync_hit) begin
              r_state    <= DATA;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
              o_locked   <= 1'b1;
            end
          end
          DATA: begin
            if (w_byte_done) begin
              o_data       <= w_byte;
              o_data_valid <= 1'b1;
              o_sof        <= (r_byte_cnt == 8'd0);
              o_eof        <= w_last_byte;
              o_parity_err <= w_perr;
              r_bit_cnt    <= '0;
              r_byte_cnt   <= r_byte_cnt + 8'd1;
              if (w_last_byte) begin
                r_state     <= HUNT;
                r_hunt_cnt  <= '0;
                o_locked    <= 1'b0;
                o_frame_cnt <= o_frame_cnt + 8'd1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrz_frame_deframer.sv
// Directed + randomized bench for nrz_frame_deframer against a bit-stream reference model.
module tb_nrz_frame_deframer;

  localparam logic [7:0] TB_SYNC = 8'hD5;
  localparam int unsigned TB_PB  = 4;
`ifdef DEFRAMER_PARITY_CHECK_EN
  localparam bit          TB_PAR = 1'b1;
  localparam int unsigned TB_BPB = 9;
`else
  localparam bit          TB_PAR = 1'b0;
  localparam int unsigned TB_BPB = 8;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       perr;
    logic [7:0] fc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, a_nrz, a_en, b_nrz, b_en;
  logic [7:0] a_data, a_fc, b_data, b_fc;
  logic a_valid, a_sof, a_eof, a_locked, a_perr;
  logic b_valid, b_sof, b_eof, b_locked, b_perr;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned n_checked = 0;
  bit  hist[$];
  ev_t obs_q[$];
  ev_t exp_q[$];

  always #5 clk = ~clk;

  nrz_frame_deframer #(.SYNC_WORD(TB_SYNC), .PAYLOAD_BYTES(TB_PB)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_nrz(a_nrz), .i_bit_en(a_en),
    .o_data(a_data), .o_data_valid(a_valid), .o_sof(a_sof), .o_eof(a_eof),
    .o_locked(a_locked), .o_frame_cnt(a_fc), .o_parity_err(a_perr)
  );

  nrz_frame_deframer #(.SYNC_WORD(8'h00), .PAYLOAD_BYTES(1)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_nrz(b_nrz), .i_bit_en(b_en),
    .o_data(b_data), .o_data_valid(b_valid), .o_sof(b_sof), .o_eof(b_eof),
    .o_locked(b_locked), .o_frame_cnt(b_fc), .o_parity_err(b_perr)
  );

  always @(negedge clk) begin
    if (a_valid === 1'b1) obs_q.push_back(ev_t'({a_data, a_sof, a_eof, a_perr, a_fc}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: scan everything fed since reset; 8 fresh bits matching sync opens a frame.
  function automatic void model_run();
    int unsigned i, fresh, fidx;
    logic [7:0]  win, d;
    ev_t         e;
    i = 0; fresh = 0; fidx = 0; win = '0;
    exp_q.delete();
    while (i < hist.size()) begin
      win = {win[6:0], hist[i]};
      i++;
      fresh++;
      if (fresh >= 8 && win == TB_SYNC) begin
        for (int unsigned b = 0; b < TB_PB; b++) begin
          if (i + TB_BPB > hist.size()) begin
            i = hist.size();
            break;
          end
          d = '0;
          for (int unsigned k = 0; k < 8; k++) begin
            d = {d[6:0], hist[i]};
            i++;
          end
          e.perr = 1'b0;
          if (TB_PAR) begin
            e.perr = (^d) ^ hist[i];
            i++;
          end
          e.data = d;
          e.sof  = (b == 0);
          e.eof  = (b == TB_PB - 1);
          e.fc   = 8'(e.eof ? fidx + 1 : fidx);
          exp_q.push_back(e);
        end
        fidx++;
        fresh = 0;
      end
    end
  endfunction

  task automatic check_stream(input string tag);
    int unsigned n;
    model_run();
    chk({tag, "/count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned k = n_checked; k < n; k++)
      chk($sformatf("%s/ev%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
    n_checked = n;
  endtask

  task automatic send_bit_a(input bit b, input int gap);
    int unsigned g;
    g = (gap < 0) ? $urandom_range(0, 2) : gap;
    a_nrz = b;
    a_en  = 1'b1;
    hist.push_back(b);
    tick();
    a_en = 1'b0;
    repeat (g) tick();
  endtask

  task automatic send_byte_a(input logic [7:0] d, input int gap, input int tail, input bit with_par);
    int unsigned nb;
    nb = (with_par && TB_PAR) ? 9 : 8;
    for (int unsigned i = 0; i < nb; i++)
      send_bit_a((i < 8) ? d[7 - i] : ^d, (i == nb - 1) ? tail : gap);
  endtask

  task automatic send_frame_a(input logic [7:0] p [4], input int gap);
    send_byte_a(TB_SYNC, gap, gap, 1'b0);
    for (int unsigned b = 0; b < 4; b++) send_byte_a(p[b], gap, gap, 1'b1);
  endtask

  task automatic send_bit_b(input bit b, input int unsigned gap);
    b_nrz = b;
    b_en  = 1'b1;
    tick();
    b_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    a_en  = 1'b0;
    b_en  = 1'b0;
    tick();
    tick();
    chk({tag, "/rst_a"}, 32'({a_data, a_valid, a_sof, a_eof, a_locked, a_fc, a_perr}), 32'd0);
    chk({tag, "/rst_b"}, 32'({b_data, b_valid, b_sof, b_eof, b_locked, b_fc, b_perr}), 32'd0);
    rst_n = 1'b1;
    obs_q.delete();
    hist.delete();
    n_checked = 0;
  endtask

  initial begin
    logic [7:0] pl [4];
    logic [7:0] bd;
    rst_n = 1'b0; a_nrz = 1'b0; a_en = 1'b0; b_nrz = 1'b0; b_en = 1'b0;

    // Test 1: basic frame, bit strobe every other clock
    do_reset("t1");
    send_byte_a(TB_SYNC, 1, 1, 1'b0);
    chk("t1/locked", 32'(a_locked), 32'd1);
    send_byte_a(8'h12, 1, 1, 1'b1);
    send_byte_a(8'h34, 1, 1, 1'b1);
    send_byte_a(8'h56, 1, 1, 1'b1);
    send_byte_a(8'h78, 1, 0, 1'b1);
    chk("t1/eof_cycle", 32'({a_valid, a_eof, a_locked, a_data, a_fc}), 32'({1'b1, 1'b1, 1'b0, 8'h78, 8'd1}));
    repeat (3) tick();
    chk("t1/unlocked", 32'({a_locked, a_fc}), 32'({1'b0, 8'd1}));
    check_stream("t1");

    // Test 2: SYNC_WORD=00 must not match on cleared contents; PAYLOAD_BYTES=1 boundary
    repeat (3) send_bit_b(1'b0, 1);
    chk("t2/after3", 32'(b_locked), 32'd0);
    repeat (4) send_bit_b(1'b0, 1);
    chk("t2/after7", 32'(b_locked), 32'd0);
    send_bit_b(1'b0, 0);
    chk("t2/after8", 32'(b_locked), 32'd1);
    tick();
    bd = 8'($urandom_range(0, 255));
    for (int unsigned i = 0; i < 7; i++) send_bit_b(bd[7 - i], 1);
    if (TB_PAR) begin
      send_bit_b(bd[0], 1);
      send_bit_b(^bd, 0);
    end else begin
      send_bit_b(bd[0], 0);
    end
    chk("t2/single", 32'({b_valid, b_sof, b_eof, b_locked, b_perr, b_data, b_fc}),
        32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, bd, 8'd1}));
    tick();

    // Test 3: sliding alignment behind a 3-bit prefix
    send_bit_a(1'b1, 0); send_bit_a(1'b0, 0); send_bit_a(1'b1, 0);
    pl[0] = 8'hA5;
    for (int unsigned b = 1; b < 4; b++) pl[b] = 8'($urandom_range(0, 255));
    send_frame_a(pl, -1);
    repeat (3) tick();
    check_stream("t3");
    chk("t3/fc", 32'(a_fc), 32'd2);

    // Test 4: reset mid-frame discards the partial frame
    for (int unsigned b = 0; b < 4; b++) pl[b] = 8'($urandom_range(0, 255));
    send_byte_a(TB_SYNC, 1, 1, 1'b0);
    send_byte_a(pl[0], 1, 1, 1'b1);
    send_byte_a(pl[1], 1, 1, 1'b1);
    for (int unsigned i = 0; i < 3; i++) send_bit_a(pl[2][7 - i], 1);
    repeat (2) tick();
    check_stream("t4pre");
    do_reset("t4");
    repeat (20) tick();
    chk("t4/quiet", 32'(obs_q.size()), 32'd0);
    for (int unsigned b = 0; b < 4; b++) pl[b] = 8'($urandom_range(0, 255));
    send_frame_a(pl, -1);
    repeat (3) tick();
    check_stream("t4post");
    chk("t4/fc", 32'(a_fc), 32'd1);

    // Test 5: 256 back-to-back frames, frame counter wraps
    do_reset("t5");
    for (int unsigned f = 0; f < 256; f++) begin
      for (int unsigned b = 0; b < 4; b++) pl[b] = 8'($urandom_range(0, 255));
      send_frame_a(pl, 0);
    end
    repeat (3) tick();
    check_stream("t5");
    chk("t5/wrap", 32'({a_fc, a_locked}), 32'({8'h00, 1'b0}));

`ifdef DEFRAMER_PARITY_CHECK_EN
    // Test 6: parity error flag, byte still delivered
    do_reset("t6");
    send_byte_a(TB_SYNC, 0, 0, 1'b0);
    send_byte_a(8'h07, 0, 0, 1'b0);
    send_bit_a(1'b1, 0);
    send_byte_a(8'h07, 0, 0, 1'b0);
    send_bit_a(1'b0, 0);
    send_byte_a(8'h3C, 0, 0, 1'b1);
    send_byte_a(8'hC1, 0, 0, 1'b1);
    repeat (3) tick();
    check_stream("t6");
    if (obs_q.size() >= 2) begin
      chk("t6/good", 32'({obs_q[0].data, obs_q[0].perr}), 32'({8'h07, 1'b0}));
      chk("t6/bad",  32'({obs_q[1].data, obs_q[1].perr}), 32'({8'h07, 1'b1}));
    end
`endif

    // Test 7: random noise between frames with random strobe spacing
    do_reset("t7");
    for (int unsigned f = 0; f < 24; f++) begin
      repeat ($urandom_range(0, 12)) send_bit_a(1'($urandom_range(0, 1)), -1);
      for (int unsigned b = 0; b < 4; b++) pl[b] = 8'($urandom_range(0, 255));
      send_frame_a(pl, -1);
    end
    repeat (3) tick();
    check_stream("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
